// File: rtl/sort_ctrl.sv
// Ascending bubble sort of N 4-bit entries using one shared magnitude comparator,
// one adjacent-pair compare per clock, with early exit on a swap-free pass.

module compmag (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       agtb,
   output logic       aeqb,
   output logic       altb
);
   assign agtb = (a > b);
   assign aeqb = (a == b);
   assign altb = (a < b);
endmodule

// state | meaning
// IDLE  | waiting for start, dout/swap_cnt hold last result
// CMP   | comparing r[j] with r[j+1], one pair per clock
// DONE  | one-cycle completion pulse, then back to IDLE
module sort_ctrl #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [4*N-1:0] din,
   output logic           busy,
   output logic           done,
   output logic [4*N-1:0] dout,
   output logic [7:0]     swap_cnt
);
   localparam int JW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_CMP  = 3'b010,
      S_DONE = 3'b100
   } state_t;

   state_t         state_q;
   logic [3:0]     r_q [N];
   logic [3:0]     r_d [N];
   logic [JW-1:0]  j_q;
   logic [JW-1:0]  lim_q;
   logic [JW-1:0]  jp1;
   logic           swapped_q;
   logic [4*N-1:0] dout_q;
   logic [4*N-1:0] r_flat_d;
   logic [7:0]     swap_cnt_q;
   logic [3:0]     cmp_a;
   logic [3:0]     cmp_b;
   logic           agtb;
   logic           unused_aeqb;
   logic           unused_altb;
   logic           pass_end;
   logic           sort_end;

   assign jp1   = j_q + JW'(1);
   assign cmp_a = r_q[j_q];
   assign cmp_b = r_q[jp1];

   compmag u_cmp (
      .a    (cmp_a),
      .b    (cmp_b),
      .agtb (agtb),
      .aeqb (unused_aeqb),
      .altb (unused_altb)
   );

   // Entry array after this cycle's conditional swap; equal values stay put.
   always_comb begin
      for (int i = 0; i < N; i++) r_d[i] = r_q[i];
      if (agtb) begin
         r_d[j_q] = cmp_b;
         r_d[jp1] = cmp_a;
      end
      r_flat_d = '0;
      for (int i = 0; i < N; i++) r_flat_d[4*i +: 4] = r_d[i];
   end

   assign pass_end = (j_q == lim_q - JW'(1));
   assign sort_end = pass_end && (!(swapped_q || agtb) || (lim_q == JW'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         for (int i = 0; i < N; i++) r_q[i] <= '0;
         j_q        <= '0;
         lim_q      <= JW'(N - 1);
         swapped_q  <= 1'b0;
         dout_q     <= '0;
         swap_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_CMP;
                  for (int i = 0; i < N; i++) r_q[i] <= din[4*i +: 4];
                  j_q        <= '0;
                  lim_q      <= JW'(N - 1);
                  swapped_q  <= 1'b0;
                  swap_cnt_q <= '0;
               end
            end
            S_CMP: begin
               for (int i = 0; i < N; i++) r_q[i] <= r_d[i];
               if (agtb) begin
                  swapped_q  <= 1'b1;
                  swap_cnt_q <= swap_cnt_q + 8'd1;
               end
               if (sort_end) begin
                  state_q <= S_DONE;
                  dout_q  <= r_flat_d;
               end else if (pass_end) begin
                  lim_q     <= lim_q - JW'(1);
                  j_q       <= '0;
                  swapped_q <= 1'b0;
               end else begin
                  j_q <= jp1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = (state_q == S_CMP);
   assign done     = (state_q == S_DONE);
   assign dout     = dout_q;
   assign swap_cnt = swap_cnt_q;
endmodule

// File: tb/tb_sort_ctrl.sv
// Self-checking bench for sort_ctrl at N=2, 4 and 8 against a counting-sort /
// inversion-count reference model.

module tb_sort_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start2 = 1'b0, start4 = 1'b0, start8 = 1'b0;
   logic [7:0]  din2 = '0;
   logic [15:0] din4 = '0;
   logic [31:0] din8 = '0;
   logic        busy2, busy4, busy8, done2, done4, done8;
   logic [7:0]  dout2;
   logic [15:0] dout4;
   logic [31:0] dout8;
   logic [7:0]  sc2, sc4, sc8;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   sort_ctrl #(.N(2)) u2 (.clk(clk), .rst(rst), .start(start2), .din(din2), .busy(busy2),
                          .done(done2), .dout(dout2), .swap_cnt(sc2));
   sort_ctrl #(.N(4)) u4 (.clk(clk), .rst(rst), .start(start4), .din(din4), .busy(busy4),
                          .done(done4), .dout(dout4), .swap_cnt(sc4));
   sort_ctrl #(.N(8)) u8 (.clk(clk), .rst(rst), .start(start8), .din(din8), .busy(busy8),
                          .done(done8), .dout(dout8), .swap_cnt(sc8));

   function automatic logic get_busy(input int sel);
      return (sel == 2) ? busy2 : (sel == 4) ? busy4 : busy8;
   endfunction

   function automatic logic get_done(input int sel);
      return (sel == 2) ? done2 : (sel == 4) ? done4 : done8;
   endfunction

   function automatic logic [31:0] get_dout(input int sel);
      return (sel == 2) ? {24'd0, dout2} : (sel == 4) ? {16'd0, dout4} : dout8;
   endfunction

   function automatic logic [7:0] get_sc(input int sel);
      return (sel == 2) ? sc2 : (sel == 4) ? sc4 : sc8;
   endfunction

   task automatic drive(input int sel, input logic s, input logic [31:0] d);
      case (sel)
         2:       begin start2 = s; din2 = d[7:0];  end
         4:       begin start4 = s; din4 = d[15:0]; end
         default: begin start8 = s; din8 = d;       end
      endcase
   endtask

   // Sorted result by counting values; swaps = inversion count; passes = largest
   // count of strictly-greater entries to the left of any entry, plus the
   // swap-free confirming pass unless the pass limit shrinks to one first.
   function automatic void model(input int n, input logic [31:0] d, output logic [31:0] srt,
                                 output int inv, output int cmp);
      int v[8];
      int pmax, left, passes, pos;
      srt = '0; inv = 0; pmax = 0; cmp = 0; pos = 0;
      for (int i = 0; i < n; i++) v[i] = int'(d[4*i +: 4]);
      for (int i = 0; i < n; i++) begin
         left = 0;
         for (int k = 0; k < i; k++) if (v[k] > v[i]) left++;
         inv += left;
         if (left > pmax) pmax = left;
      end
      passes = (pmax + 1 > n - 1) ? n - 1 : pmax + 1;
      for (int k = 0; k < passes; k++) cmp += n - 1 - k;
      for (int val = 0; val < 16; val++)
         for (int i = 0; i < n; i++)
            if (v[i] == val) begin
               srt[4*pos +: 4] = 4'(val);
               pos++;
            end
   endfunction

   // Call with time just after a rising edge; returns the same way.
   task automatic run_sort(input int sel, input int n, input logic [31:0] d, input string nm,
                           input int repulse_at);
      logic [31:0] exp_srt;
      int          exp_inv, exp_cmp, cyc;
      logic        busy_ok;
      model(n, d, exp_srt, exp_inv, exp_cmp);
      drive(sel, 1'b1, d);
      @(posedge clk); #1;
      drive(sel, 1'b0, $urandom());
      cyc = 0;
      busy_ok = 1'b1;
      while (!get_done(sel) && cyc < 100) begin
         if (!get_busy(sel)) busy_ok = 1'b0;
         @(posedge clk); #1;
         cyc++;
         drive(sel, (cyc == repulse_at), $urandom());
      end
      drive(sel, 1'b0, $urandom());
      checks++;
      if (cyc !== exp_cmp) begin
         failures++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", nm, cyc, exp_cmp);
      end
      checks++;
      if (!busy_ok || get_busy(sel) !== 1'b0) begin
         failures++;
         $display("FAIL %s busy: high_during_cmp=%0b busy_at_done=%0b, expected 1/0", nm,
                  busy_ok, get_busy(sel));
      end
      checks++;
      if (get_dout(sel) !== exp_srt) begin
         failures++;
         $display("FAIL %s dout: got %h, expected %h", nm, get_dout(sel), exp_srt);
      end
      checks++;
      if (get_sc(sel) !== 8'(exp_inv)) begin
         failures++;
         $display("FAIL %s swap_cnt: got %0d, expected %0d", nm, get_sc(sel), exp_inv);
      end
      @(posedge clk); #1;
      checks++;
      if (get_done(sel) !== 1'b0 || get_busy(sel) !== 1'b0 || get_dout(sel) !== exp_srt) begin
         failures++;
         $display("FAIL %s after_done: done=%0b busy=%0b dout=%h, expected 0 0 %h", nm,
                  get_done(sel), get_busy(sel), get_dout(sel), exp_srt);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy2, busy4, busy8, done2, done4, done8} !== 6'b0 ||
          dout2 !== '0 || dout4 !== '0 || dout8 !== '0 ||
          sc2 !== '0 || sc4 !== '0 || sc8 !== '0) begin
         failures++;
         $display("FAIL reset_state: busy=%b%b%b done=%b%b%b dout=%h/%h/%h sc=%0d/%0d/%0d, expected zeros",
                  busy2, busy4, busy8, done2, done4, done8, dout2, dout4, dout8, sc2, sc4, sc8);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_sort(4, 4, 32'h0000_4321, "sorted", -1);
      run_sort(4, 4, 32'h0000_2479, "reverse", -1);
      run_sort(4, 4, 32'h0000_3535, "duplicates", -1);
   endtask

   task automatic test_start_repulse();
      run_sort(4, 4, 32'h0000_0F0F, "repulse", 2);
      repeat (4) begin
         @(posedge clk); #1;
         checks++;
         if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL repulse_idle: done=%0b busy=%0b, expected 0 0", done4, busy4);
         end
      end
      run_sort(4, 4, 32'h0000_1A6C, "fresh_after_repulse", -1);
   endtask

   task automatic test_mid_reset();
      drive(4, 1'b1, 32'h0000_2479);
      @(posedge clk); #1;
      drive(4, 1'b0, 32'h0000_2479);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || dout4 !== '0 || sc4 !== '0) begin
         failures++;
         $display("FAIL mid_reset: busy=%0b done=%0b dout=%h sc=%0d, expected 0 0 0000 0",
                  busy4, done4, dout4, sc4);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         checks++;
         if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_idle: done=%0b busy=%0b, expected 0 0", done4, busy4);
         end
      end
      run_sort(4, 4, 32'h0000_2479, "after_reset", -1);
   endtask

   task automatic test_n2();
      run_sort(2, 2, 32'h0000_0038, "n2_swap", -1);
      run_sort(2, 2, 32'h0000_0083, "n2_sorted", -1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 200; t++) run_sort(8, 8, $urandom(), "rand_n8", -1);
      for (int t = 0; t < 20; t++) run_sort(4, 4, {16'd0, 16'($urandom())}, "rand_n4", -1);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_repulse();
      test_mid_reset();
      test_n2();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
- Sequencer that sorts N unsigned 4-bit values into ascending order using a single shared compmag instance (bubble sort, one compare per clock).
- Sits between a parallel-load source (switch bank or register file) and the display/output stage.
- Only agtb is used for the swap decision; aeqb and altb are left unconnected.
- The comparator is time-multiplexed over all adjacent pairs. No second comparator is permitted.

Parameters:
- N, 4, number of 4-bit entries; legal range 2..8.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to load din and sort; sampled only in IDLE
- din  input  4*N  unsorted entries, entry i = din[4i+3:4i]
- busy  output  1  high while comparing (state CMP)
- done  output  1  one-cycle pulse, high while state DONE
- dout  output  4*N  sorted entries, entry 0 smallest; same packing as din
- swap_cnt  output  8  number of swaps performed in the last sort

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all entry registers, dout and swap_cnt = 0.
  - busy=0, done=0, j=0, lim=N-1, swapped=0.
  - Reset mid-sort aborts immediately. No partial result survives.
- States:
  - IDLE: waits for start. busy=0, done=0, and dout holds the previous result.
  - CMP: one adjacent-pair compare per cycle.
  - DONE: single cycle, then IDLE unconditionally.
- IDLE -> CMP, at an edge with start=1:
  - r[i] <= din entry i; j <= 0; lim <= N-1; swapped <= 0; swap_cnt <= 0.
- CMP datapath:
  - compmag a = r[j], b = r[j+1], combinational within the cycle.
  - At each edge, if agtb=1: swap r[j] and r[j+1], set swapped, swap_cnt += 1.
  - Equal values are never swapped (stable sort).
- CMP, end of pass (j == lim-1 at the edge):
  - If no swap occurred in this pass (including the current edge), or lim == 1 -> DONE.
  - Otherwise: lim <= lim-1, j <= 0, swapped <= 0, stay in CMP.
  - Not at end of pass: j <= j+1.
- DONE:
  - dout updates to the final r contents on the edge that enters DONE.
  - done=1 for exactly one cycle; next edge -> IDLE.
- Latency, counted from start sampled at edge E0:
  - busy is high from E0 to the edge entering DONE.
  - Best case (already sorted): N-1 compares; done high between E(N-1) and E(N).
  - Worst case: N(N-1)/2 compares.
- start handling:
  - Ignored while in CMP or DONE. No queueing.
  - din changes after E0 have no effect on the sort in progress.
- Outputs are registered except busy and done, which decode directly from the state register (glitch-free, one-hot encoding).
- swap_cnt never exceeds 28 (N=8 worst case); no saturation logic.

Test Plan:
- N=4, din entries {1,2,3,4} (entry0..3), start pulse at E0 -> 3 CMP cycles, done high between E3 and E4, dout {1,2,3,4}, swap_cnt=0, busy low from E3.
- N=4, reverse {9,7,4,2} -> 6 compares, done after E6, dout {2,4,7,9}, swap_cnt=6.
- N=4, with duplicates {5,3,5,3} -> dout {3,3,5,5}; equal pairs produce no swap (agtb=0 path exercised); swap_cnt=3.
- N=4, {15,0,15,0} followed by a start re-pulse during CMP -> re-pulse ignored, single done pulse, dout {0,0,15,15}; a new start in IDLE afterwards begins a fresh sort.
- Assert rst for 1 cycle at E2 of a reverse-order sort -> immediately state IDLE, dout=0, swap_cnt=0, busy=0, no done pulse; the next start sorts correctly.
- N=2 build, {8,3} -> one compare, swap, done after E1, dout {3,8}, swap_cnt=1; plus a random 200-vector sweep at N=8 checked against a reference sort.
